pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//   Generic elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, ...) with valid/ready handshake.
//   Carries an opaque DATA_W payload (instr/pc/pre_pc/commit packed by the caller).
//   Supports flush (bubble insert) and hold (stall) from the hazard controller.
//   Optional 2-entry skid buffer breaks the combinational ready path for timing.
// PARAMETERS
//   DATA_W     97                              payload width: instr[32] + pc[32] + pre_pc[32] + commit[1]
//   NOP_VALUE  {32'h00000013,32'h0,32'h0,1'b0} payload driven whenever the output slot is empty
// PORTS
//   clk        in   1       clock, rising edge
//   rst        in   1       reset, synchronous, active-high
//   flush_i    in   1       discard all held entries (bubble); highest priority after rst
//   hold_i     in   1       freeze stage: no accept, no emit, contents kept
//   in_valid   in   1       upstream payload valid
//   in_ready   out  1       stage can accept this cycle
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       output slot valid (masked by hold_i)
//   out_ready  in   1       downstream accepts
//   out_data   out  DATA_W  output payload; NOP_VALUE when slot empty
//   occupancy  out  2       entries held: 0..1, or 0..2 with skid
// BEHAVIOUR
//   - Transfer in/out occurs when valid && ready are both high at a rising edge.
//   - Reset: main_v=0, skid_v=0, out_data=NOP_VALUE, out_valid=0, occupancy=0, in_ready=1 from the first cycle after reset.
//   - Priority: rst > flush_i > hold_i > normal operation.
//   - flush_i: next cycle all entries are invalid and out_data=NOP_VALUE.
//     A same-cycle input handshake completes (in_ready is unaffected by flush) but its data is dropped.
//   - hold_i (without flush): in_ready=0, out_valid=0 (combinational mask), registers unchanged.
//     Contents reappear unchanged once hold_i drops.
//   - Latency: 1 cycle, in_data -> out_data. Throughput: 1 transfer/cycle when out_ready is held high.
//   - Main slot on drain (out handshake, no refill): main_v->0 and payload reloads NOP_VALUE.
//   - Simultaneous in and out handshake: main slot loads the new data; occupancy is unchanged.
//   - Valid data is never overwritten while out_ready=0; no loss and no duplication.
// CONFIGURATION
//   Macro PIPE_SKID_EN:
//   - Defined: 3-state FSM EMPTY -> FULL -> SKID.
//     - in_ready = ~skid_v, registered; no combinational path from out_ready.
//     - EMPTY + in         -> FULL.
//     - FULL + in + ~out   -> SKID; the new data goes to the skid entry.
//     - FULL + ~in + out   -> EMPTY.
//     - SKID + out         -> FULL; skid moves to main, skid_v->0.
//     - SKID: in_ready=0.
//     - occupancy range 0..2.
//   - Undefined: single register.
//     - in_ready = ~hold_i & (~main_v | out_ready), combinational.
//     - occupancy range 0..1; skid logic absent.
//   - Handshake-visible behaviour is identical except in_ready timing.
// STRUCTURE
//   - Shared package pipe_pkg: NOP_INSTR (32'h00000013), NOP_PC, NOP_PRE_PC, NOP_COMMIT, PIPE_PAYLOAD_W (97).
//     Also payload pack/unpack functions; NOP_VALUE default is built from these.
//   - Sub-module pipe_skid_slot (one valid+data register with load/clear) is instantiated as main and skid entry.
//   - FSM encoding is local to this module.
// TESTING
//   - Reset mid-stream: occupancy=2, assert rst 1 cycle -> next cycle out_valid=0, out_data=NOP_VALUE, occupancy=0.
//   - Streaming: in_valid=1 with in_data 0x1..0x8 on consecutive cycles, out_ready=1
//     -> out_data 0x1..0x8 on consecutive cycles, 1 cycle later, no gaps.
//   - Backpressure: out_ready=0 for 3 cycles while pushing A,B,C
//     -> SKID variant holds A,B, in_ready=0, C waits; after release outputs A,B,C in order.
//   - Flush with concurrent input: occupancy=1 holding A, flush_i=1 and in handshake with B
//     -> next cycle out_valid=0, out_data=NOP_VALUE; B never appears.
//   - Hold: holding A, hold_i=1 for 4 cycles with out_ready=1
//     -> out_valid=0, in_ready=0 throughout; A emitted the cycle hold_i drops.
//   - Flush and hold together: flush_i=1 and hold_i=1 -> flush wins, stage empty next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline payload definitions: NOP constants, payload layout
// and pack/unpack helpers used by every inter-stage register.
package pipe_pkg;

    localparam int PIPE_INSTR_W   = 32;
    localparam int PIPE_PC_W      = 32;
    localparam int PIPE_PAYLOAD_W = 97;

    localparam logic [PIPE_INSTR_W-1:0] NOP_INSTR  = 32'h00000013;
    localparam logic [PIPE_PC_W-1:0]    NOP_PC     = '0;
    localparam logic [PIPE_PC_W-1:0]    NOP_PRE_PC = '0;
    localparam logic                    NOP_COMMIT = 1'b0;

    typedef logic [PIPE_PAYLOAD_W-1:0] pipe_word_t;

    typedef struct packed {
        logic [PIPE_INSTR_W-1:0] instr;
        logic [PIPE_PC_W-1:0]    pc;
        logic [PIPE_PC_W-1:0]    pre_pc;
        logic                    commit;
    } pipe_payload_t;

    // Bubble payload: addi x0,x0,0 with zero pcs and no commit.
    localparam pipe_word_t PIPE_NOP_VALUE =
        {NOP_INSTR, NOP_PC, NOP_PRE_PC, NOP_COMMIT};

    function automatic pipe_word_t pipe_pack(
        input logic [PIPE_INSTR_W-1:0] instr,
        input logic [PIPE_PC_W-1:0]    pc,
        input logic [PIPE_PC_W-1:0]    pre_pc,
        input logic                    commit
    );
        return {instr, pc, pre_pc, commit};
    endfunction

    function automatic pipe_payload_t pipe_unpack(
        input pipe_word_t w
    );
        return pipe_payload_t'(w);
    endfunction

    function automatic logic pipe_is_nop(
        input pipe_word_t w
    );
        return w == PIPE_NOP_VALUE;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One valid+payload storage entry with load and clear.
// Clear wins over load and reloads the bubble payload.
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int                 DATA_W    = PIPE_PAYLOAD_W,
    parameter logic [DATA_W-1:0]  RST_VALUE = DATA_W'(PIPE_NOP_VALUE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Next-state selection: clear > load > keep.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = RST_VALUE;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    // Entry storage with synchronous reset to an empty bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= RST_VALUE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register with flush/hold and valid/ready handshake.
// Define PIPE_SKID_EN for the 2-entry skid variant with registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = PIPE_PAYLOAD_W,
    parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(PIPE_NOP_VALUE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              hold_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              in_hs;
    logic              out_hs;
    logic              main_v;
    logic [DATA_W-1:0] main_q;
    logic              main_load;
    logic              main_clear;
    logic [DATA_W-1:0] main_d;

    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;
    assign out_valid = main_v & ~hold_i;
    assign out_data  = main_q;

    pipe_skid_slot #(
        .DATA_W    (DATA_W),
        .RST_VALUE (NOP_VALUE)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .load_i  (main_load),
        .clear_i (main_clear),
        .data_i  (main_d),
        .valid_o (main_v),
        .data_o  (main_q)
    );

`ifdef PIPE_SKID_EN

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e            state_q;
    logic              in_ready_q;
    logic [1:0]        occ_q;
    logic              skid_v;
    logic [DATA_W-1:0] skid_q;
    logic              skid_load;
    logic              skid_clear;

    // Ready comes from a flop; hold only masks it, out_ready never reaches it.
    assign in_ready  = in_ready_q & ~hold_i;
    assign occupancy = occ_q;

    pipe_skid_slot #(
        .DATA_W    (DATA_W),
        .RST_VALUE (NOP_VALUE)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (in_data),
        .valid_o (skid_v),
        .data_o  (skid_q)
    );

    // Steer loads/clears into main and skid entries from state and handshakes.
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        main_d     = in_data;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (flush_i) begin
            main_clear = 1'b0 | 1'b1;
            skid_clear = 1'b1;
        end else if (!hold_i) begin
            case (state_q)
                ST_EMPTY: begin
                    main_load = in_hs;
                end
                ST_FULL: begin
                    if (in_hs && !out_hs) begin
                        skid_load = 1'b1;
                    end else if (in_hs) begin
                        main_load = 1'b1;
                    end else if (out_hs) begin
                        main_clear = 1'b1;
                    end
                end
                ST_SKID: begin
                    if (out_hs) begin
                        main_load  = 1'b1;
                        main_d     = skid_q;
                        skid_clear = 1'b1;
                    end
                end
                default: begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    // Occupancy FSM with registered in_ready and occupancy outputs.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            occ_q      <= 2'd0;
        end else if (!hold_i) begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_hs) begin
                        state_q <= ST_FULL;
                        occ_q   <= 2'd1;
                    end
                end
                ST_FULL: begin
                    if (in_hs && !out_hs) begin
                        state_q    <= ST_SKID;
                        in_ready_q <= 1'b0;
                        occ_q      <= 2'd2;
                    end else if (!in_hs && out_hs) begin
                        state_q <= ST_EMPTY;
                        occ_q   <= 2'd0;
                    end
                end
                ST_SKID: begin
                    if (out_hs) begin
                        state_q    <= ST_FULL;
                        in_ready_q <= 1'b1;
                        occ_q      <= 2'd1;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                    occ_q      <= 2'd0;
                end
            endcase
        end
    end

`else

    // Accept when free or when the held entry leaves this same cycle.
    assign in_ready  = ~hold_i & (~main_v | out_ready);
    assign occupancy = {1'b0, main_v};

    // Single-entry control: flush > refill > drain.
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        main_d     = in_data;
        if (flush_i) begin
            main_clear = 1'b1;
        end else if (in_hs) begin
            main_load = 1'b1;
        end else if (out_hs) begin
            main_clear = 1'b1;
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (default or PIPE_SKID_EN).
module tb_pipe_stage_reg;

    localparam int W = 97;
    localparam logic [W-1:0] NOP = {32'h00000013, 32'h0, 32'h0, 1'b0};

    logic         clk = 1'b0;
    logic         rst;
    logic         flush_i;
    logic         hold_i;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] da;
    logic [W-1:0] db;
    logic [W-1:0] dc;

    pipe_stage_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush_i),
        .hold_i    (hold_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_empty(input string tag);
        check({tag, "_ov"}, W'(out_valid), W'(0));
        check({tag, "_od"}, out_data, NOP);
        check({tag, "_occ"}, W'(occupancy), W'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        da = W'(97'hA0A0);
        db = W'(97'hB0B0);
        dc = W'(97'hC0C0);
        rst = 1'b1;
        flush_i = 1'b0;
        hold_i = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        expect_empty("rst");
        check("rst_ir", W'(in_ready), W'(1));

        // streaming 1..8, one cycle latency, no gaps
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data = W'(i);
            tick();
            check("strm_d", out_data, W'(i));
            check("strm_v", W'(out_valid), W'(1));
        end
        in_valid = 1'b0;
        tick();
        expect_empty("strm_end");

        // backpressure A,B,C
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = da;
        tick();
`ifdef PIPE_SKID_EN
        in_data = db;
        tick();
        check("bp_occ2", W'(occupancy), W'(2));
        check("bp_ir0", W'(in_ready), W'(0));
        in_data = dc;
        tick();
        check("bp_holdA", out_data, da);
        check("bp_occ2b", W'(occupancy), W'(2));
        out_ready = 1'b1;
        tick();
        check("bp_B", out_data, db);
        tick();
        check("bp_C", out_data, dc);
`else
        check("bp_ir0", W'(in_ready), W'(0));
        in_data = db;
        tick();
        check("bp_holdA", out_data, da);
        check("bp_occ1", W'(occupancy), W'(1));
        tick();
        check("bp_holdA2", out_data, da);
        out_ready = 1'b1;
        tick();
        check("bp_B", out_data, db);
        in_data = dc;
        tick();
        check("bp_C", out_data, dc);
`endif
        in_valid = 1'b0;
        tick();
        expect_empty("bp_end");

        // flush with concurrent input handshake
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = da;
        tick();
        out_ready = 1'b1;
        in_data = db;
        flush_i = 1'b1;
        #1;
        check("fl_ir", W'(in_ready), W'(1));
        tick();
        flush_i = 1'b0;
        in_valid = 1'b0;
        expect_empty("fl");
        tick();
        tick();
        check("fl_noB", W'(out_valid), W'(0));

        // hold for 4 cycles
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = da;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        hold_i = 1'b1;
        repeat (4) begin
            #1;
            check("hold_ov", W'(out_valid), W'(0));
            check("hold_ir", W'(in_ready), W'(0));
            tick();
        end
        hold_i = 1'b0;
        #1;
        check("hold_relv", W'(out_valid), W'(1));
        check("hold_reld", out_data, da);
        tick();
        expect_empty("hold_end");

        // flush and hold together
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = da;
        tick();
        in_valid = 1'b0;
        flush_i = 1'b1;
        hold_i = 1'b1;
        tick();
        flush_i = 1'b0;
        hold_i = 1'b0;
        expect_empty("flhd");

        // reset mid-stream
        in_valid = 1'b1;
        in_data = da;
        tick();
        in_data = db;
        tick();
`ifdef PIPE_SKID_EN
        check("mrst_occ", W'(occupancy), W'(2));
`else
        check("mrst_occ", W'(occupancy), W'(1));
`endif
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_empty("mrst");
        check("mrst_ir", W'(in_ready), W'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
